// File: rtl/riscv_multicycle_sequencer_pkg.sv
// riscv_pkg: shared state encoding and control constants for the multicycle sequencer
//   seq_state_e : 4-bit sequencer state
//   PC_SEL_*    : pc_sel encodings
//   TRAP_*      : trap_cause encodings
//   WB_*        : writeback select encodings
package riscv_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        FETCH_REQ  = 4'd1,
        FETCH_WAIT = 4'd2,
        DECODE     = 4'd3,
        EXECUTE    = 4'd4,
        MEM_REQ    = 4'd5,
        MEM_WAIT   = 4'd6,
        WRITEBACK  = 4'd7,
        TRAP       = 4'd8
    } seq_state_e;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

    localparam logic [1:0] TRAP_NONE        = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL     = 2'b01;
    localparam logic [1:0] TRAP_BUS_TIMEOUT = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/riscv_multicycle_sequencer_wait_timer.sv
// riscv_wait_timer: clearable saturating wait counter for memory handshake phases
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the counter (takes priority over inc)
//   inc        : this cycle's handshake did not complete
//   expired    : this failing cycle brings the count to MEM_TIMEOUT (never when MEM_TIMEOUT=0)
module riscv_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;

    // Flag the failing cycle itself so the FSM steps into TRAP right after it.
    assign expired = (MEM_TIMEOUT != 0) && inc && (cnt_q == LAST);

endmodule

// File: rtl/riscv_multicycle_sequencer.sv
// riscv_multicycle_sequencer: steps instructions through fetch/decode/execute/memory/writeback
//   halt_req                       : stop at the next instruction boundary
//   imem_req/gnt/rvalid, ir_we     : instruction fetch handshake and IR load strobe
//   reg_write..wb_sel, illegal_instr, branch_taken : decoded control and ALU compare
//   dmem_req/we/gnt/rvalid         : data memory handshake
//   rf_we, wb_sel_o, pc_we, pc_sel : writeback and PC update controls
//   instr_retired, retire_count    : retire pulse and wrapping counter
//   halted, trap, trap_cause, state_o : status and debug
module riscv_multicycle_sequencer
    import riscv_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt_req,
    output logic             imem_req,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    output logic             ir_we,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             branch,
    input  logic             jump,
    input  logic [1:0]       wb_sel,
    input  logic             illegal_instr,
    input  logic             branch_taken,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    output logic             rf_we,
    output logic [1:0]       wb_sel_o,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             instr_retired,
    output logic [CNT_W-1:0] retire_count,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [3:0]       state_o
);

    seq_state_e       state_q, state_d;
    logic             reg_write_q, reg_write_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic             branch_q, branch_d, jump_q, jump_d, taken_q, taken_d, halted_q, halted_d;
    logic [1:0]       wb_sel_q, wb_sel_d, trap_cause_q, trap_cause_d;
    logic [CNT_W-1:0] retire_count_q, retire_count_d;
    logic             wait_inc, wait_expired;

    riscv_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!wait_inc),
        .inc     (wait_inc),
        .expired (wait_expired)
    );

    always_comb begin
        state_d  = state_q;
        wait_inc = 1'b0;
        case (state_q)
            IDLE:       state_d = halt_req ? IDLE : FETCH_REQ;
            FETCH_REQ: begin
                wait_inc = !imem_gnt;
                if (imem_gnt) state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                wait_inc = !imem_rvalid;
                if (imem_rvalid) state_d = DECODE;
            end
            DECODE:     state_d = illegal_instr ? TRAP : EXECUTE;
            EXECUTE:    state_d = (mem_read_q || mem_write_q) ? MEM_REQ : WRITEBACK;
            MEM_REQ: begin
                wait_inc = !dmem_gnt;
                if (dmem_gnt) state_d = mem_write_q ? WRITEBACK : MEM_WAIT;
            end
            MEM_WAIT: begin
                wait_inc = !dmem_rvalid;
                if (dmem_rvalid) state_d = WRITEBACK;
            end
            WRITEBACK:  state_d = halt_req ? IDLE : FETCH_REQ;
            default:    state_d = TRAP;
        endcase
        if (wait_expired) state_d = TRAP;
        {reg_write_d, mem_read_d, mem_write_d, branch_d, jump_d, wb_sel_d} =
            (state_q == DECODE) ? {reg_write, mem_read, mem_write, branch, jump, wb_sel}
                                : {reg_write_q, mem_read_q, mem_write_q, branch_q, jump_q, wb_sel_q};
        taken_d        = (state_q == EXECUTE) ? branch_taken : taken_q;
        trap_cause_d   = (state_d == TRAP && state_q != TRAP)
                       ? (wait_expired ? TRAP_BUS_TIMEOUT : TRAP_ILLEGAL) : trap_cause_q;
        retire_count_d = retire_count_q + CNT_W'(state_q == WRITEBACK);
        // IDLE is only entered from reset, WRITEBACK or IDLE, so this marks a halt-induced idle.
        halted_d       = (state_d == IDLE) && halt_req;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q        <= IDLE;
            reg_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            branch_q       <= 1'b0;
            jump_q         <= 1'b0;
            taken_q        <= 1'b0;
            halted_q       <= 1'b0;
            wb_sel_q       <= WB_ALU;
            trap_cause_q   <= TRAP_NONE;
            retire_count_q <= '0;
        end else begin
            state_q        <= state_d;
            reg_write_q    <= reg_write_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            branch_q       <= branch_d;
            jump_q         <= jump_d;
            taken_q        <= taken_d;
            halted_q       <= halted_d;
            wb_sel_q       <= wb_sel_d;
            trap_cause_q   <= trap_cause_d;
            retire_count_q <= retire_count_d;
        end

    assign imem_req      = state_q == FETCH_REQ;
    assign ir_we         = (state_q == FETCH_WAIT) && imem_rvalid;
    assign dmem_req      = state_q == MEM_REQ;
    assign dmem_we       = (state_q == MEM_REQ) && mem_write_q;
    assign rf_we         = (state_q == WRITEBACK) && reg_write_q;
    assign pc_we         = state_q == WRITEBACK;
    assign instr_retired = state_q == WRITEBACK;
    assign pc_sel        = (state_q != WRITEBACK) ? PC_SEL_PLUS4 :
                           jump_q                 ? PC_SEL_JUMP :
                           (branch_q && taken_q)  ? PC_SEL_BRANCH : PC_SEL_PLUS4;
    assign wb_sel_o      = wb_sel_q;
    assign retire_count  = retire_count_q;
    assign halted        = halted_q;
    assign trap          = state_q == TRAP;
    assign trap_cause    = trap_cause_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_riscv_multicycle_sequencer.sv
// tb_riscv_multicycle_sequencer: directed scoreboard bench for the multicycle sequencer
module tb_riscv_multicycle_sequencer;
    import riscv_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, halt_req = 1'b1;
    logic imem_gnt = 1'b0, imem_rvalid = 1'b0, dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0, branch = 1'b0, jump = 1'b0;
    logic illegal_instr = 1'b0, branch_taken = 1'b0;
    logic [1:0] wb_sel = 2'b00;
    logic imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, instr_retired, halted, trap;
    logic [1:0] wb_sel_o, pc_sel, trap_cause;
    logic [3:0] retire_count, state_o;
    logic [22:0] outs;

    int total = 0, bad = 0;
    int i_gw = 0, d_gw = 0, d_lat = 1;
    int i_rc = 0, d_rc = 0, i_left = 0, d_left = 0;
    logic i_pf = 1'b0, d_pf = 1'b0;

    typedef struct {
        logic       rf;
        logic [1:0] wb;
        logic [1:0] pc;
        logic       we;
        int         cyc;
        logic [3:0] cnt;
    } exp_t;
    exp_t sb[$];
    exp_t cur;
    int cyc = 0, start = 0, n_ret = 0, issued = 0;
    logic req_prev = 1'b0, we_seen = 1'b0, cnt_chk = 1'b0;
    logic [3:0] exp_cnt = 4'd0;

    always #5 clk = ~clk;

    riscv_multicycle_sequencer #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .halt_req(halt_req),
        .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .ir_we(ir_we),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
        .jump(jump), .wb_sel(wb_sel), .illegal_instr(illegal_instr), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .rf_we(rf_we), .wb_sel_o(wb_sel_o), .pc_we(pc_we), .pc_sel(pc_sel),
        .instr_retired(instr_retired), .retire_count(retire_count), .halted(halted),
        .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
    );

    assign outs = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, instr_retired, halted, trap,
                   wb_sel_o, pc_sel, trap_cause, retire_count, state_o};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responders: gnt after i_gw/d_gw request cycles, rvalid 1 (fetch) or d_lat (load) cycles after gnt.
    initial forever begin
        @(negedge clk);
        imem_rvalid = 1'b0;
        dmem_rvalid = 1'b0;
        if (!rst_n) begin
            i_rc = 0; d_rc = 0; i_left = 0; d_left = 0;
            i_pf = 1'b0; d_pf = 1'b0; imem_gnt = 1'b0; dmem_gnt = 1'b0;
        end else begin
            if (i_pf) i_left = 1;
            if (d_pf) d_left = d_lat;
            if (i_left > 0) begin i_left--; imem_rvalid = (i_left == 0); end
            if (d_left > 0) begin d_left--; dmem_rvalid = (d_left == 0); end
            if (!imem_req) i_rc = 0;
            if (!dmem_req) d_rc = 0;
            imem_gnt = imem_req && (i_rc >= i_gw);
            dmem_gnt = dmem_req && (d_rc >= d_gw);
            if (imem_req) i_rc++;
            if (dmem_req) d_rc++;
            i_pf = imem_req && imem_gnt;
            d_pf = dmem_req && dmem_gnt && !dmem_we;
        end
    end

    // Monitor: pops the scoreboard on every retire pulse.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            req_prev = 1'b0;
            cnt_chk  = 1'b0;
        end else begin
            if (cnt_chk) begin
                chk("retire_count", 32'(retire_count), 32'(cur.cnt));
                cnt_chk = 1'b0;
            end
            if (imem_req && !req_prev) begin start = cyc; we_seen = 1'b0; end
            req_prev = imem_req;
            if (dmem_req && dmem_we) we_seen = 1'b1;
            if (instr_retired) begin
                n_ret++;
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_retire: retire pulse with empty scoreboard at cycle %0d", cyc);
                end else begin
                    cur = sb.pop_front();
                    chk("rf_we", 32'(rf_we), 32'(cur.rf));
                    chk("wb_sel_o", 32'(wb_sel_o), 32'(cur.wb));
                    chk("pc_sel", 32'(pc_sel), 32'(cur.pc));
                    chk("pc_we", 32'(pc_we), 32'd1);
                    chk("dmem_we_seen", 32'(we_seen), 32'(cur.we));
                    chk("cycles", 32'(cyc - start + 1), 32'(cur.cyc));
                    cnt_chk = 1'b1;
                end
            end
        end
    end

    task automatic issue(input logic rw, mr, mw, br, jp, input logic [1:0] wbs, input logic tk,
                         input int dl, input int igw, input logic [1:0] epc, input int ecyc);
        exp_t e;
        {reg_write, mem_read, mem_write, branch, jump, wb_sel, branch_taken} = {rw, mr, mw, br, jp, wbs, tk};
        d_lat = dl;
        i_gw = igw;
        exp_cnt = exp_cnt + 1'b1;
        e.rf = rw; e.wb = wbs; e.pc = epc; e.we = mw; e.cyc = ecyc; e.cnt = exp_cnt;
        sb.push_back(e);
        issued++;
    endtask

    task automatic wait_ret(input int target);
        int n = 0;
        while (n_ret < target && n < 60) begin @(negedge clk); #1; n++; end
        chk("retire_reached", 32'(n_ret), 32'(target));
    endtask

    task automatic wait_state(input logic [3:0] s, input string name);
        int n = 0;
        while (state_o !== s && n < 60) begin @(negedge clk); #1; n++; end
        chk(name, 32'(state_o), 32'(s));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        halt_req = 1'b1;
        {reg_write, mem_read, mem_write, branch, jump, wb_sel, branch_taken, illegal_instr} = '0;
        i_gw = 0; d_gw = 0; d_lat = 1;
        repeat (2) @(negedge clk);
        #1 chk("reset_outputs", 32'(outs), 32'd0);
        rst_n = 1'b1;
        exp_cnt = 4'd0;
    endtask

    initial begin
        logic any;
        int n;
        int n_mr;
        do_reset();
        @(negedge clk); #1;
        chk("halted_in_idle", 32'({halted, imem_req, state_o}), 32'({1'b1, 1'b0, IDLE}));

        // ADD, LW with 3-cycle rvalid, SW, BEQ taken/not, JAL, fetch gnt wait, zero-wait LW
        issue(1, 0, 0, 0, 0, WB_ALU, 0, 1, 0, PC_SEL_PLUS4, 5);
        halt_req = 1'b0;
        wait_ret(issued);
        issue(1, 1, 0, 0, 0, WB_MEM, 0, 3, 0, PC_SEL_PLUS4, 9);   wait_ret(issued);
        issue(0, 0, 1, 0, 0, WB_ALU, 0, 1, 0, PC_SEL_PLUS4, 6);   wait_ret(issued);
        issue(0, 0, 0, 1, 0, WB_ALU, 1, 1, 0, PC_SEL_BRANCH, 5);  wait_ret(issued);
        issue(0, 0, 0, 1, 0, WB_ALU, 0, 1, 0, PC_SEL_PLUS4, 5);   wait_ret(issued);
        issue(1, 0, 0, 0, 1, WB_PC4, 0, 1, 0, PC_SEL_JUMP, 5);    wait_ret(issued);
        issue(1, 0, 0, 0, 0, WB_ALU, 0, 1, 2, PC_SEL_PLUS4, 7);   wait_ret(issued);
        issue(1, 1, 0, 0, 0, WB_MEM, 0, 1, 0, PC_SEL_PLUS4, 7);   wait_ret(issued);

        // halt raised during a load's MEM_WAIT
        issue(1, 1, 0, 0, 0, WB_MEM, 0, 3, 0, PC_SEL_PLUS4, 9);
        wait_state(MEM_WAIT, "reach_mem_wait");
        halt_req = 1'b1;
        wait_ret(issued);
        @(negedge clk); #1;
        chk("halt_idle", 32'({halted, state_o}), 32'({1'b1, IDLE}));
        repeat (3) begin @(negedge clk); #1; end
        chk("halt_hold", 32'({halted, imem_req, state_o}), 32'({1'b1, 1'b0, IDLE}));
        issue(1, 0, 0, 0, 0, WB_ALU, 0, 1, 0, PC_SEL_PLUS4, 5);
        halt_req = 1'b0;
        @(negedge clk); #1;
        chk("halt_release", 32'({halted, imem_req, state_o}), 32'({1'b0, 1'b1, FETCH_REQ}));
        wait_ret(issued);

        // asynchronous reset during FETCH_WAIT with a nonzero retire count
        {reg_write, mem_read, mem_write, branch, jump} = 5'b10000;
        wait_state(FETCH_WAIT, "reach_fetch_wait");
        #1 rst_n = 1'b0;
        #1 chk("reset_mid_fetch", 32'(outs), 32'd0);
        do_reset();

        // illegal instruction: trap, then quiet until reset
        {reg_write, mem_write, illegal_instr} = 3'b111;
        halt_req = 1'b0;
        wait_state(TRAP, "reach_trap_illegal");
        chk("trap_illegal", 32'({trap, trap_cause}), 32'({1'b1, TRAP_ILLEGAL}));
        any = 1'b0;
        repeat (10) begin
            @(negedge clk); #1;
            any = any | rf_we | pc_we | dmem_req | imem_req | ir_we | instr_retired | (state_o != TRAP);
        end
        chk("trap_quiet", 32'(any), 32'd0);
        chk("trap_cause_held", 32'({trap, trap_cause}), 32'({1'b1, TRAP_ILLEGAL}));
        do_reset();
        chk("trap_cleared", 32'({trap, trap_cause}), 32'd0);

        // bus timeout: store whose dmem_gnt never comes
        mem_write = 1'b1;
        d_gw = 1000;
        halt_req = 1'b0;
        wait_state(MEM_REQ, "reach_mem_req");
        n_mr = 0;
        n = 0;
        while (state_o == MEM_REQ && n < 20) begin n_mr++; n++; @(negedge clk); #1; end
        chk("timeout_mem_req_cycles", 32'(n_mr), 32'd4);
        chk("trap_timeout", 32'({trap, trap_cause, state_o}), 32'({1'b1, TRAP_BUS_TIMEOUT, TRAP}));
        do_reset();

        // 16 retires wrap the 4-bit counter to 0
        for (int k = 0; k < 16; k++) begin
            issue(1, 0, 0, 0, 0, WB_ALU, 0, 1, 0, PC_SEL_PLUS4, 5);
            halt_req = 1'b0;
            wait_ret(issued);
        end
        halt_req = 1'b1;
        repeat (2) begin @(negedge clk); #1; end
        chk("wrap_zero", 32'({state_o, retire_count}), 32'({IDLE, 4'd0}));
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
